alu_pipe: RTL and testbench
===========================

# alu_pipe

Registered, parametrised successor to the CPU's combinational ALU. Executes the full 6502/2A03 arithmetic and logic set with N/V/Z/C flag generation and 16-bit effective-address addition, behind a valid/ready handshake. Optionally splits address adds into a low-byte cycle plus a conditional high-byte fix cycle, with page-cross reporting. Sits between the decode/sequencer stage and the register file and flag register.

## Interface
- BYTE_W, 8: data byte width.
- ADDR_W, 16: address/result width; must equal 2*BYTE_W.
- SPLIT_ADD, 1: 1 = ALU_ADD takes an extra cycle on low-byte carry; 0 = ALU_ADD always single cycle.

Clock and reset: one clock, `clk_i`; reset `rstn_i` is asynchronous and active-low.

- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- valid_i  in  1  request valid
- ready_o  out  1  request accepted when valid_i && ready_o
- alu_op_i  in  alu_op_t  operation
- op_A_i  in  ADDR_W  operand A (byte ops use [BYTE_W-1:0])
- op_B_i  in  ADDR_W  operand B
- carry_i  in  1  current C flag (ADC/SBC/ROL/ROR)
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- res_o  out  ADDR_W  result
- flags_o  out  4  {N,V,Z,C}
- flags_we_o  out  4  per-flag update mask, same order
- page_cross_o  out  1  low-byte carry on ALU_ADD

## Operation
- Byte ops; res_o upper byte is 0, N=res[7], Z=(res[7:0]==0):
  - ALU_ADC: A+B+carry_i. C=carry out. V=(A7==B7)&&(R7!=A7). we NVZC.
  - ALU_SBC: A+~B+carry_i, same C/V rules. we NVZC.
  - ALU_AND, ALU_ORA, ALU_EOR: we NZ.
  - ALU_ASL: C=A7. ALU_LSR: C=A0. ALU_ROL: shifts in carry_i at bit 0, C=A7. ALU_ROR: shifts in carry_i at bit 7, C=A0. All four: we NZC.
  - ALU_INC, ALU_DEC: A±1, wraps FF↔00. we NZ.
  - ALU_CMP: res=A-B. C=(A>=B) unsigned. we NZC.
- ALU_BYPASS_A / ALU_BYPASS_B: full-width pass. we 0.
- ALU_ADD_ZEROPAGE: res={0, (A+B)[7:0]}, wraps within page 0. page_cross_o=0. we 0.
- ALU_ADD: full-width A+B, modulo 2^ADDR_W. page_cross_o = carry out of the low byte. we 0.
- Undefined op: res 0, flags 0, we 0; still completes.
- FSM states: IDLE, HI_FIX.
  - IDLE → HI_FIX on accepting ALU_ADD with SPLIT_ADD=1 and low-byte carry. Output register loads {A_hi+B_hi, lo}, valid_o stays 0.
  - HI_FIX → IDLE next cycle: high byte incremented, valid_o=1, page_cross_o=1.
- ready_o = rstn_i && state==IDLE && (!valid_o || ready_i).
- Output register holds res/flags/we/page_cross stable while valid_o && !ready_i.

## Timing
- Reset values: valid_o=0, res_o=0, flags_o=0, flags_we_o=0, page_cross_o=0, state=IDLE. ready_o=0 while rstn_i low, 1 on the first cycle after release.
- Latency 1 cycle: accepted at edge k, valid_o high after edge k.
- Split ALU_ADD with carry: latency 2 cycles. ready_o=0 during HI_FIX.
- Back-to-back: a new accept is allowed in the same cycle the result is consumed (valid_o && ready_i); throughput 1/cycle.
- Reset asserted in HI_FIX: operation dropped, no valid_o.
- valid_i while ready_o=0: ignored. The requester holds its request.

## Structure
- Shared CPU package holds:
  - alu_op_t extended with the new ops, existing encodings unchanged.
  - Flag index constants FLAG_N/V/Z/C.
  - `BYTE.
- Sub-module alu_byte_core: combinational byte datapath. Inputs op, A, B, carry_i. Outputs result, flags, we. alu_pipe adds the address adder, FSM and output register.

## Test plan
- ADC A=0x50 B=0x50 carry_i=0 → res 0x00A0, flags N=1 V=1 Z=0 C=0, we 1111, 1-cycle latency.
- SBC A=0x00 B=0x01 carry_i=1 → res 0x00FF, N=1 V=0 Z=0 C=0. CMP A=0x40 B=0x40 → Z=1 C=1, we 1011.
- ALU_ADD A=0x12F0 B=0x0020, SPLIT_ADD=1 → 2-cycle latency, res 0x1310, page_cross_o=1, ready_o low one cycle. Same with SPLIT_ADD=0 → 1 cycle.
- ALU_ADD_ZEROPAGE A=0x00F0 B=0x0020 → res 0x0010, page_cross_o=0.
- ready_i held low 3 cycles with valid_o=1 → outputs stable, ready_o=0, no accept. Then a stream of 4 ROL ops with ready_i=1 → one result per cycle.
- Reset pulsed during HI_FIX → valid_o never rises for that op, all outputs 0, ready_o=1 after release.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared CPU definitions: ALU opcodes, flag bit positions and the byte width.
package alu_pipe_pkg;

  localparam int BYTE = 8;

  // Encodings 0..13 match the original combinational ALU; 14/15 are the address adds.
  typedef enum logic [4:0] {
    ALU_ADC          = 5'd0,
    ALU_SBC          = 5'd1,
    ALU_AND          = 5'd2,
    ALU_ORA          = 5'd3,
    ALU_EOR          = 5'd4,
    ALU_ASL          = 5'd5,
    ALU_LSR          = 5'd6,
    ALU_ROL          = 5'd7,
    ALU_ROR          = 5'd8,
    ALU_INC          = 5'd9,
    ALU_DEC          = 5'd10,
    ALU_CMP          = 5'd11,
    ALU_BYPASS_A     = 5'd12,
    ALU_BYPASS_B     = 5'd13,
    ALU_ADD_ZEROPAGE = 5'd14,
    ALU_ADD          = 5'd15
  } alu_op_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_HI_FIX = 1'b1
  } alu_state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/alu_byte_core.sv
// Combinational 6502 byte datapath: result, {N,V,Z,C} and the flag write mask.
// Non-byte and undefined ops produce a zero result with an empty mask.
module alu_byte_core
  import alu_pipe_pkg::*;
#(
  parameter int BYTE_W = BYTE
) (
  input  alu_op_t             op_i,
  input  logic [BYTE_W-1:0]   a_i,
  input  logic [BYTE_W-1:0]   b_i,
  input  logic                carry_i,
  output logic [BYTE_W-1:0]   res_o,
  output logic [3:0]          flags_o,
  output logic [3:0]          we_o
);

  logic [BYTE_W-1:0] b_eff;
  logic              add_cin;
  logic [BYTE_W:0]   sum;
  logic [BYTE_W-1:0] res;
  logic              c_flag;
  logic              v_flag;
  logic [3:0]        we;

  // SBC and CMP share the adder with the inverted operand; CMP ignores carry_i.
  always_comb begin
    b_eff   = ((op_i == ALU_SBC) || (op_i == ALU_CMP)) ? ~b_i : b_i;
    add_cin = (op_i == ALU_CMP) ? 1'b1 : carry_i;
    sum     = {1'b0, a_i} + {1'b0, b_eff} + {{BYTE_W{1'b0}}, add_cin};
  end

  always_comb begin
    res    = '0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    we     = 4'b0000;
    case (op_i)
      ALU_ADC, ALU_SBC: begin
        res    = sum[BYTE_W-1:0];
        c_flag = sum[BYTE_W];
        v_flag = (a_i[BYTE_W-1] == b_eff[BYTE_W-1]) && (res[BYTE_W-1] != a_i[BYTE_W-1]);
        we     = 4'b1111;
      end
      ALU_AND: begin res = a_i & b_i; we = 4'b1010; end
      ALU_ORA: begin res = a_i | b_i; we = 4'b1010; end
      ALU_EOR: begin res = a_i ^ b_i; we = 4'b1010; end
      ALU_ASL: begin
        res = {a_i[BYTE_W-2:0], 1'b0}; c_flag = a_i[BYTE_W-1]; we = 4'b1011;
      end
      ALU_LSR: begin
        res = {1'b0, a_i[BYTE_W-1:1]}; c_flag = a_i[0]; we = 4'b1011;
      end
      ALU_ROL: begin
        res = {a_i[BYTE_W-2:0], carry_i}; c_flag = a_i[BYTE_W-1]; we = 4'b1011;
      end
      ALU_ROR: begin
        res = {carry_i, a_i[BYTE_W-1:1]}; c_flag = a_i[0]; we = 4'b1011;
      end
      ALU_INC: begin res = a_i + {{(BYTE_W-1){1'b0}}, 1'b1}; we = 4'b1010; end
      ALU_DEC: begin res = a_i - {{(BYTE_W-1){1'b0}}, 1'b1}; we = 4'b1010; end
      ALU_CMP: begin
        res = sum[BYTE_W-1:0]; c_flag = sum[BYTE_W]; we = 4'b1011;
      end
      default: ;
    endcase
  end

  assign res_o   = res;
  assign we_o    = we;
  assign flags_o = {res[BYTE_W-1], v_flag, (res == '0), c_flag} & we;

endmodule

// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshake and optional split 16-bit address add.
// States: ST_IDLE accepts requests; ST_HI_FIX increments the high byte after a low-byte carry.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int BYTE_W    = BYTE,
  parameter int ADDR_W    = 16,
  parameter int SPLIT_ADD = 1
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  alu_op_t           alu_op_i,
  input  logic [ADDR_W-1:0] op_A_i,
  input  logic [ADDR_W-1:0] op_B_i,
  input  logic              carry_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [ADDR_W-1:0] res_o,
  output logic [3:0]        flags_o,
  output logic [3:0]        flags_we_o,
  output logic              page_cross_o
);

  alu_state_t        state_q, state_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] res_q, res_d;
  logic [3:0]        flags_q, flags_d;
  logic [3:0]        we_q, we_d;
  logic              pc_q, pc_d;

  logic [BYTE_W-1:0] core_res;
  logic [3:0]        core_flags;
  logic [3:0]        core_we;
  logic [BYTE_W:0]   lo_sum;
  logic [BYTE_W-1:0] hi_sum;
  logic [ADDR_W-1:0] full_sum;
  logic              accept;

  alu_byte_core #(.BYTE_W(BYTE_W)) u_core (
    .op_i    (alu_op_i),
    .a_i     (op_A_i[BYTE_W-1:0]),
    .b_i     (op_B_i[BYTE_W-1:0]),
    .carry_i (carry_i),
    .res_o   (core_res),
    .flags_o (core_flags),
    .we_o    (core_we)
  );

  assign lo_sum   = {1'b0, op_A_i[BYTE_W-1:0]} + {1'b0, op_B_i[BYTE_W-1:0]};
  assign hi_sum   = op_A_i[ADDR_W-1:BYTE_W] + op_B_i[ADDR_W-1:BYTE_W];
  assign full_sum = op_A_i + op_B_i;

  assign ready_o = rstn_i && (state_q == ST_IDLE) && (!valid_q || ready_i);
  assign accept  = valid_i && ready_o;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    res_d   = res_q;
    flags_d = flags_q;
    we_d    = we_q;
    pc_d    = pc_q;
    case (state_q)
      ST_HI_FIX: begin
        res_d   = {res_q[ADDR_W-1:BYTE_W] + {{(BYTE_W-1){1'b0}}, 1'b1}, res_q[BYTE_W-1:0]};
        valid_d = 1'b1;
        pc_d    = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        if (accept) begin
          valid_d = 1'b1;
          flags_d = 4'b0000;
          we_d    = 4'b0000;
          pc_d    = 1'b0;
          case (alu_op_i)
            ALU_BYPASS_A:     res_d = op_A_i;
            ALU_BYPASS_B:     res_d = op_B_i;
            ALU_ADD_ZEROPAGE: res_d = {{(ADDR_W-BYTE_W){1'b0}}, lo_sum[BYTE_W-1:0]};
            ALU_ADD: begin
              if ((SPLIT_ADD != 0) && lo_sum[BYTE_W]) begin
                // High byte is fixed up next cycle; result not yet presented.
                res_d   = {hi_sum, lo_sum[BYTE_W-1:0]};
                valid_d = 1'b0;
                state_d = ST_HI_FIX;
              end else begin
                res_d = full_sum;
                pc_d  = lo_sum[BYTE_W];
              end
            end
            default: begin
              res_d   = {{(ADDR_W-BYTE_W){1'b0}}, core_res};
              flags_d = core_flags;
              we_d    = core_we;
            end
          endcase
        end else if (ready_i) begin
          valid_d = 1'b0;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      res_q   <= '0;
      flags_q <= 4'b0000;
      we_q    <= 4'b0000;
      pc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      res_q   <= res_d;
      flags_q <= flags_d;
      we_q    <= we_d;
      pc_q    <= pc_d;
    end
  end

  assign valid_o      = valid_q;
  assign res_o        = res_q;
  assign flags_o      = flags_q;
  assign flags_we_o   = we_q;
  assign page_cross_o = pc_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases plus randomized traffic against a reference model.
module tb_alu_pipe;
  import alu_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        valid_i = 1'b0, ready_i = 1'b1;
  alu_op_t     op_i = ALU_ADC;
  logic [15:0] a_i = '0, b_i = '0;
  logic        cin = 1'b0;
  logic        ready_o, valid_o, pc_o;
  logic [15:0] res_o;
  logic [3:0]  flags_o, we_o;

  logic        valid0_i = 1'b0, ready0_i = 1'b1;
  logic        ready0_o, valid0_o, pc0_o;
  logic [15:0] res0_o;
  logic [3:0]  flags0_o, we0_o;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  alu_pipe #(.BYTE_W(8), .ADDR_W(16), .SPLIT_ADD(1)) dut (
    .clk_i(clk), .rstn_i(rstn), .valid_i(valid_i), .ready_o(ready_o),
    .alu_op_i(op_i), .op_A_i(a_i), .op_B_i(b_i), .carry_i(cin),
    .valid_o(valid_o), .ready_i(ready_i), .res_o(res_o), .flags_o(flags_o),
    .flags_we_o(we_o), .page_cross_o(pc_o)
  );

  alu_pipe #(.BYTE_W(8), .ADDR_W(16), .SPLIT_ADD(0)) dut0 (
    .clk_i(clk), .rstn_i(rstn), .valid_i(valid0_i), .ready_o(ready0_o),
    .alu_op_i(op_i), .op_A_i(a_i), .op_B_i(b_i), .carry_i(cin),
    .valid_o(valid0_o), .ready_i(ready0_i), .res_o(res0_o), .flags_o(flags0_o),
    .flags_we_o(we0_o), .page_cross_o(pc0_o)
  );

  // Reference model in plain integer arithmetic.
  function automatic void model(input alu_op_t op, input logic [15:0] a, input logic [15:0] b,
                                input logic c, output logic [15:0] r, output logic [3:0] f,
                                output logic [3:0] we, output logic pc);
    int ua, ub, sa, sb, ci, s, ss;
    bit byte_op, v, cy;
    ua = a[7:0]; ub = b[7:0]; ci = c;
    sa = ua >= 128 ? ua - 256 : ua;
    sb = ub >= 128 ? ub - 256 : ub;
    r = '0; f = '0; we = '0; pc = 1'b0; v = 0; cy = 0; s = 0; byte_op = 1;
    case (op)
      ALU_ADC: begin s = ua + ub + ci; cy = s > 255; ss = sa + sb + ci;
                     v = (ss > 127) || (ss < -128); we = 4'b1111; end
      ALU_SBC: begin s = ua + (255 - ub) + ci; cy = s > 255; ss = sa - sb - 1 + ci;
                     v = (ss > 127) || (ss < -128); we = 4'b1111; end
      ALU_AND: begin s = ua & ub; we = 4'b1010; end
      ALU_ORA: begin s = ua | ub; we = 4'b1010; end
      ALU_EOR: begin s = ua ^ ub; we = 4'b1010; end
      ALU_ASL: begin s = ua * 2; cy = ua >= 128; we = 4'b1011; end
      ALU_LSR: begin s = ua / 2; cy = (ua % 2) == 1; we = 4'b1011; end
      ALU_ROL: begin s = ua * 2 + ci; cy = ua >= 128; we = 4'b1011; end
      ALU_ROR: begin s = ua / 2 + ci * 128; cy = (ua % 2) == 1; we = 4'b1011; end
      ALU_INC: begin s = ua + 1; we = 4'b1010; end
      ALU_DEC: begin s = ua + 255; we = 4'b1010; end
      ALU_CMP: begin s = ua - ub + 256; cy = ua >= ub; we = 4'b1011; end
      ALU_BYPASS_A: begin byte_op = 0; r = a; end
      ALU_BYPASS_B: begin byte_op = 0; r = b; end
      ALU_ADD_ZEROPAGE: begin byte_op = 0; r = 16'((ua + ub) % 256); end
      ALU_ADD: begin byte_op = 0; r = 16'((int'(a) + int'(b)) % 65536); pc = (ua + ub) > 255; end
      default: begin byte_op = 0; end
    endcase
    if (byte_op) begin
      r = 16'(s % 256);
      f = {r[7], v, (r == 16'h0), cy} & we;
    end
  endfunction

  // Presents one request on the SPLIT_ADD=1 instance; returns at 1 after the edge that shows valid_o.
  task automatic issue(input alu_op_t op, input logic [15:0] a, input logic [15:0] b,
                       input logic c, output int lat);
    int k;
    op_i = op; a_i = a; b_i = b; cin = c; valid_i = 1'b1;
    #1;
    k = 0;
    while (!ready_o && k < 20) begin @(posedge clk); #1; k++; end
    @(posedge clk); #1;
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 10) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    rstn = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (ready_o !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", ready_o); end
    total++;
    if ({valid_o, res_o, flags_o, we_o, pc_o} !== 25'h0) begin
      bad++; $display("FAIL reset_outputs got v=%b r=%h f=%b we=%b pc=%b want all 0",
                      valid_o, res_o, flags_o, we_o, pc_o);
    end
    rstn = 1'b1;
    #1;
    total++;
    if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b want=1", ready_o); end
  endtask

  task automatic test_byte_ops();
    int lat;
    @(posedge clk); #1;
    issue(ALU_ADC, 16'h0050, 16'h0050, 1'b0, lat);
    total++;
    if ({res_o, flags_o, we_o} !== {16'h00A0, 4'b1100, 4'b1111} || lat != 1) begin
      bad++; $display("FAIL adc got r=%h f=%b we=%b lat=%0d want r=00a0 f=1100 we=1111 lat=1",
                      res_o, flags_o, we_o, lat);
    end
    issue(ALU_SBC, 16'h0000, 16'h0001, 1'b1, lat);
    total++;
    if ({res_o, flags_o, we_o} !== {16'h00FF, 4'b1000, 4'b1111} || lat != 1) begin
      bad++; $display("FAIL sbc got r=%h f=%b we=%b lat=%0d want r=00ff f=1000 we=1111 lat=1",
                      res_o, flags_o, we_o, lat);
    end
    issue(ALU_CMP, 16'h0040, 16'h0040, 1'b0, lat);
    total++;
    if ({res_o, flags_o, we_o} !== {16'h0000, 4'b0011, 4'b1011}) begin
      bad++; $display("FAIL cmp got r=%h f=%b we=%b want r=0000 f=0011 we=1011", res_o, flags_o, we_o);
    end
  endtask

  task automatic test_split_add();
    int lat;
    @(posedge clk); #1;
    op_i = ALU_ADD; a_i = 16'h12F0; b_i = 16'h0020; cin = 1'b0; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    total++;
    if ({valid_o, ready_o} !== 2'b00) begin
      bad++; $display("FAIL split_hifix got valid=%b ready=%b want 0 0", valid_o, ready_o);
    end
    @(posedge clk); #1;
    total++;
    if ({valid_o, res_o, pc_o, we_o} !== {1'b1, 16'h1310, 1'b1, 4'b0000}) begin
      bad++; $display("FAIL split_result got v=%b r=%h pc=%b we=%b want v=1 r=1310 pc=1 we=0000",
                      valid_o, res_o, pc_o, we_o);
    end
    valid0_i = 1'b1;
    @(posedge clk); #1;
    valid0_i = 1'b0;
    total++;
    if ({valid0_o, res0_o, pc0_o} !== {1'b1, 16'h1310, 1'b1}) begin
      bad++; $display("FAIL nosplit_add got v=%b r=%h pc=%b want v=1 r=1310 pc=1",
                      valid0_o, res0_o, pc0_o);
    end
    issue(ALU_ADD, 16'h1234, 16'h0011, 1'b0, lat);
    total++;
    if ({res_o, pc_o} !== {16'h1245, 1'b0} || lat != 1) begin
      bad++; $display("FAIL add_nocarry got r=%h pc=%b lat=%0d want r=1245 pc=0 lat=1", res_o, pc_o, lat);
    end
    issue(ALU_ADD_ZEROPAGE, 16'h00F0, 16'h0020, 1'b0, lat);
    total++;
    if ({res_o, pc_o, we_o} !== {16'h0010, 1'b0, 4'b0000} || lat != 1) begin
      bad++; $display("FAIL zeropage got r=%h pc=%b we=%b lat=%0d want r=0010 pc=0 we=0000 lat=1",
                      res_o, pc_o, we_o, lat);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [15:0] hold_r, er;
    logic [3:0]  hold_f, ef, ewe;
    logic        epc;
    logic [15:0] ra [4];
    logic        rc [4];
    @(posedge clk); #1;
    ready_i = 1'b0;
    issue(ALU_EOR, 16'h003C, 16'h00FF, 1'b0, lat);
    hold_r = res_o; hold_f = flags_o;
    model(ALU_EOR, 16'h003C, 16'h00FF, 1'b0, er, ef, ewe, epc);
    total++;
    if ({res_o, flags_o} !== {er, ef}) begin
      bad++; $display("FAIL stall_first got r=%h f=%b want r=%h f=%b", res_o, flags_o, er, ef);
    end
    op_i = ALU_AND; a_i = 16'h00F0; b_i = 16'h0033; valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      total++;
      if ({ready_o, valid_o, res_o, flags_o} !== {1'b0, 1'b1, hold_r, hold_f}) begin
        bad++; $display("FAIL stall_hold cyc=%0d got rdy=%b v=%b r=%h f=%b want rdy=0 v=1 r=%h f=%b",
                        i, ready_o, valid_o, res_o, flags_o, hold_r, hold_f);
      end
      @(posedge clk); #1;
    end
    ready_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    model(ALU_AND, 16'h00F0, 16'h0033, 1'b0, er, ef, ewe, epc);
    total++;
    if ({valid_o, res_o, flags_o} !== {1'b1, er, ef}) begin
      bad++; $display("FAIL stall_release got v=%b r=%h f=%b want v=1 r=%h f=%b",
                      valid_o, res_o, flags_o, er, ef);
    end
    for (int i = 0; i < 4; i++) begin
      ra[i] = 16'($urandom);
      rc[i] = 1'($urandom);
    end
    for (int i = 0; i <= 4; i++) begin
      if (i > 0) begin
        model(ALU_ROL, ra[i-1], 16'h0, rc[i-1], er, ef, ewe, epc);
        total++;
        if ({valid_o, res_o, flags_o, we_o} !== {1'b1, er, ef, ewe}) begin
          bad++; $display("FAIL rol_stream idx=%0d got v=%b r=%h f=%b we=%b want v=1 r=%h f=%b we=%b",
                          i - 1, valid_o, res_o, flags_o, we_o, er, ef, ewe);
        end
      end
      if (i < 4) begin
        op_i = ALU_ROL; a_i = ra[i]; b_i = 16'h0; cin = rc[i]; valid_i = 1'b1;
        @(posedge clk); #1;
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic test_random();
    logic [24:0] q[$];
    logic [24:0] exp_v;
    logic [15:0] er;
    logic [3:0]  ef, ewe;
    logic        epc;
    bit          acc;
    @(posedge clk); #1;
    acc = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (!valid_i || acc) begin
        valid_i = ($urandom_range(0, 3) != 0);
        op_i = alu_op_t'(5'($urandom_range(0, 19)));
        a_i = 16'($urandom);
        b_i = 16'($urandom);
        cin = 1'($urandom);
      end
      ready_i = ($urandom_range(0, 3) != 0);
      #1;
      acc = valid_i && ready_o;
      if (valid_o && ready_i) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL rand_unexpected cyc=%0d got r=%h want no result", cyc, res_o);
        end else begin
          exp_v = q.pop_front();
          if ({res_o, flags_o, we_o, pc_o} !== exp_v) begin
            bad++; $display("FAIL rand_result cyc=%0d got r=%h f=%b we=%b pc=%b want r=%h f=%b we=%b pc=%b",
                            cyc, res_o, flags_o, we_o, pc_o, exp_v[24:9], exp_v[8:5], exp_v[4:1], exp_v[0]);
          end
        end
      end
      if (acc) begin
        model(op_i, a_i, b_i, cin, er, ef, ewe, epc);
        q.push_back({er, ef, ewe, epc});
      end
      @(posedge clk); #1;
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (valid_o && q.size() > 0) begin
        exp_v = q.pop_front();
        total++;
        if ({res_o, flags_o, we_o, pc_o} !== exp_v) begin
          bad++; $display("FAIL rand_drain got r=%h want r=%h", res_o, exp_v[24:9]);
        end
      end
      @(posedge clk); #1;
    end
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL rand_lost got pending=%0d want 0", q.size());
    end
  endtask

  task automatic test_reset_hifix();
    @(posedge clk); #1;
    ready_i = 1'b1;
    op_i = ALU_ADD; a_i = 16'h12F0; b_i = 16'h0020; valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    rstn = 1'b0;
    #1;
    total++;
    if ({ready_o, valid_o, res_o, flags_o, we_o, pc_o} !== 26'h0) begin
      bad++; $display("FAIL hifix_reset got rdy=%b v=%b r=%h f=%b we=%b pc=%b want all 0",
                      ready_o, valid_o, res_o, flags_o, we_o, pc_o);
    end
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    #1;
    total++;
    if ({ready_o, valid_o} !== 2'b10) begin
      bad++; $display("FAIL hifix_release got rdy=%b v=%b want rdy=1 v=0", ready_o, valid_o);
    end
    @(posedge clk); #1;
    total++;
    if ({valid_o, res_o} !== 17'h0) begin
      bad++; $display("FAIL hifix_dropped got v=%b r=%h want v=0 r=0000", valid_o, res_o);
    end
  endtask

  task automatic test_undefined();
    int lat;
    @(posedge clk); #1;
    issue(alu_op_t'(5'd22), 16'hFFFF, 16'hFFFF, 1'b1, lat);
    total++;
    if ({res_o, flags_o, we_o, pc_o} !== 25'h0 || lat != 1) begin
      bad++; $display("FAIL undefined_op got r=%h f=%b we=%b pc=%b lat=%0d want all 0 lat=1",
                      res_o, flags_o, we_o, pc_o, lat);
    end
  endtask

  initial begin
    test_reset();
    test_byte_ops();
    test_split_add();
    test_undefined();
    test_back_to_back();
    test_random();
    test_reset_hifix();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
